pipe_stage6: RTL and testbench

Stage 6 of the timing pipeline, directly downstream of stage 5. It consumes stage 5's per-lane update decisions (U_add, candidate mode, candidate count, alpha/_alpha/beta) and the per-lane one-hot interval hits. It owns the registered state that stage 5 reads back next step: the shared interval histogram and the per-lane running maxima. After J_size accepted steps it merges the two lanes, presents one winning mode with its coefficients, and holds them under a valid/ready handshake.

---
 rtl/pipe_pkg.sv | 36 +++
 rtl/lane_best_reg.sv | 24 ++
 rtl/pipe_stage6.sv | 157 +++++++++++++++
 tb/tb_pipe_stage6.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the timing pipeline stages.
package pipe_pkg;

    localparam int unsigned WIDTH         = 16;
    localparam int unsigned INTERVAL_SIZE = 8;
    localparam int unsigned PARA          = 8;
    localparam int unsigned PARALLEL_SIZE = 2;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef struct packed {
        logic [INTERVAL_SIZE-1:0] mode;
        logic [PARA-1:0]          cnt;
        logic [WIDTH-1:0]         alpha;
        logic [WIDTH-1:0]         nalpha;
        logic [WIDTH-1:0]         beta;
    } lane_best_t;

    // Add every lane's hit bit for interval j to cnt, clamping at all-ones.
    function automatic logic [PARA-1:0] sat_hist(
        input logic [PARA-1:0]                              cnt,
        input logic [PARALLEL_SIZE-1:0][INTERVAL_SIZE-1:0] hits,
        input int unsigned                                  j
    );
        logic [PARA+1:0] sum;
        sum = {2'b00, cnt};
        for (int l = 0; l < PARALLEL_SIZE; l++) begin
            sum = sum + {{(PARA+1){1'b0}}, hits[l][j]};
        end
        if (sum > {2'b00, {PARA{1'b1}}}) begin
            return {PARA{1'b1}};
        end
        return sum[PARA-1:0];
    endfunction

endpackage

// File: rtl/lane_best_reg.sv
// Per-lane best-candidate register: synchronous clear wins over load.
module lane_best_reg
    import pipe_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       load,
    input  lane_best_t d,
    output lane_best_t q
);

    // Hold, clear or load the lane's best candidate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage6.sv
// Stage 6: interval histogram, per-lane running best and final lane merge.
module pipe_stage6
    import pipe_pkg::*;
(
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       start,
    input  logic [PARA-1:0]                            J_size,
    input  logic                                       in_valid,
    input  logic [PARALLEL_SIZE-1:0]                   U_add_i,
    input  logic [PARALLEL_SIZE-1:0][INTERVAL_SIZE-1:0] mode_i,
    input  logic [PARALLEL_SIZE-1:0][PARA-1:0]         max_cnt_i,
    input  logic [PARALLEL_SIZE-1:0][INTERVAL_SIZE-1:0] acc_interval_i,
    input  logic [PARALLEL_SIZE-1:0][WIDTH-1:0]        alpha_i,
    input  logic [PARALLEL_SIZE-1:0][WIDTH-1:0]        nalpha_i,
    input  logic [PARALLEL_SIZE-1:0][WIDTH-1:0]        beta_i,
    output logic [INTERVAL_SIZE-1:0][PARA-1:0]         interval_cnt_o,
    output logic [PARALLEL_SIZE-1:0][PARA-1:0]         max_cnt_o,
    output logic                                       busy,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [INTERVAL_SIZE-1:0]                   mode_o,
    output logic [PARA-1:0]                            cnt_o,
    output logic [WIDTH-1:0]                           alpha_o,
    output logic [WIDTH-1:0]                           nalpha_o,
    output logic [WIDTH-1:0]                           beta_o
);

    state_t                              state_q, state_d;
    logic [PARA-1:0]                     step_q, jsize_q;
    logic [INTERVAL_SIZE-1:0][PARA-1:0]  hist_q;
    lane_best_t                          res_q;
    lane_best_t                          lane_q   [PARALLEL_SIZE];
    lane_best_t                          lane_d   [PARALLEL_SIZE];
    lane_best_t                          lane_nxt [PARALLEL_SIZE];
    lane_best_t                          winner;
    logic [PARALLEL_SIZE-1:0]            lane_load;
    logic                                run_clr, beat, last_beat, res_load;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = (J_size == '0) ? DONE : RUN;
            RUN:     if (last_beat) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control decode; a start clears results so a zero-length run reports zeros.
    always_comb begin
        run_clr   = 1'b0;
        beat      = 1'b0;
        last_beat = 1'b0;
        res_load  = 1'b0;
        unique case (state_q)
            IDLE: run_clr = start;
            RUN: begin
                beat      = in_valid;
                last_beat = in_valid && (step_q == jsize_q - PARA'(1));
                res_load  = last_beat;
            end
            default: ;
        endcase
    end

    assign busy      = (state_q == RUN);
    assign out_valid = (state_q == DONE);

    // Step counter and latched run length.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_q  <= '0;
            jsize_q <= '0;
        end else if (run_clr) begin
            step_q  <= '0;
            jsize_q <= J_size;
        end else if (beat) begin
            step_q <= step_q + PARA'(1);
        end
    end

    // Saturating interval histogram shared by all lanes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
        end else if (run_clr) begin
            hist_q <= '0;
        end else if (beat) begin
            for (int j = 0; j < INTERVAL_SIZE; j++) begin
                hist_q[j] <= sat_hist(hist_q[j], acc_interval_i, j);
            end
        end
    end

    // Lane candidate packing and post-beat view used by the merge.
    always_comb begin
        for (int l = 0; l < PARALLEL_SIZE; l++) begin
            lane_d[l].mode   = mode_i[l];
            lane_d[l].cnt    = max_cnt_i[l];
            lane_d[l].alpha  = alpha_i[l];
            lane_d[l].nalpha = nalpha_i[l];
            lane_d[l].beta   = beta_i[l];
            lane_load[l]     = beat && U_add_i[l];
            lane_nxt[l]      = lane_load[l] ? lane_d[l] : lane_q[l];
            max_cnt_o[l]     = lane_q[l].cnt;
        end
    end

    for (genvar l = 0; l < PARALLEL_SIZE; l++) begin : g_lane
        lane_best_reg u_lane (
            .clk  (clk),
            .clr  (run_clr),
            .rst  (rst),
            .load (lane_load[l]),
            .d    (lane_d[l]),
            .q    (lane_q[l])
        );
    end

    // Merge: strictly larger count wins, so the lowest lane index wins ties.
    always_comb begin
        winner = lane_nxt[0];
        for (int l = 1; l < PARALLEL_SIZE; l++) begin
            if (lane_nxt[l].cnt > winner.cnt) winner = lane_nxt[l];
        end
    end

    // Result register, written on entry to DONE and held until the next start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q <= '0;
        end else if (run_clr) begin
            res_q <= '0;
        end else if (res_load) begin
            res_q <= winner;
        end
    end

    assign interval_cnt_o = hist_q;
    assign mode_o         = res_q.mode;
    assign cnt_o          = res_q.cnt;
    assign alpha_o        = res_q.alpha;
    assign nalpha_o       = res_q.nalpha;
    assign beta_o         = res_q.beta;

endmodule

// File: tb/tb_pipe_stage6.sv
// Scoreboard bench for pipe_stage6 against a histogram/best-lane model.
module tb_pipe_stage6;
    import pipe_pkg::*;

    logic                              clk = 1'b0;
    logic                              rst = 1'b1;
    logic                              start = 1'b0;
    logic [7:0]                        J_size = '0;
    logic                              in_valid = 1'b0;
    logic [1:0]                        U_add_i = '0;
    logic [1:0][7:0]                   mode_i = '0, max_cnt_i = '0, acc_interval_i = '0;
    logic [1:0][15:0]                  alpha_i = '0, nalpha_i = '0, beta_i = '0;
    logic [7:0][7:0]                   interval_cnt_o;
    logic [1:0][7:0]                   max_cnt_o;
    logic                              busy, out_valid;
    logic                              out_ready = 1'b0;
    logic [7:0]                        mode_o, cnt_o;
    logic [15:0]                       alpha_o, nalpha_o, beta_o;

    pipe_stage6 dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .J_size         (J_size),
        .in_valid       (in_valid),
        .U_add_i        (U_add_i),
        .mode_i         (mode_i),
        .max_cnt_i      (max_cnt_i),
        .acc_interval_i (acc_interval_i),
        .alpha_i        (alpha_i),
        .nalpha_i       (nalpha_i),
        .beta_i         (beta_i),
        .interval_cnt_o (interval_cnt_o),
        .max_cnt_o      (max_cnt_o),
        .busy           (busy),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .mode_o         (mode_o),
        .cnt_o          (cnt_o),
        .alpha_o        (alpha_o),
        .nalpha_o       (nalpha_o),
        .beta_o         (beta_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: plain integer histogram and per-lane best records.
    typedef struct {
        logic [7:0]  mode;
        logic [7:0]  cnt;
        logic [15:0] a, na, b;
    } res_t;

    int   m_hist [8];
    res_t m_lane [2];
    int   m_step, m_j;
    res_t exp_q [$];
    res_t last_res;

    function automatic logic [63:0] m_hist_vec();
        logic [63:0] v = '0;
        for (int j = 0; j < 8; j++) v[j*8 +: 8] = m_hist[j][7:0];
        return v;
    endfunction

    function automatic res_t m_result();
        return (m_lane[1].cnt > m_lane[0].cnt) ? m_lane[1] : m_lane[0];
    endfunction

    task automatic model_clear();
        res_t z = '{mode: 8'h0, cnt: 8'h0, a: 16'h0, na: 16'h0, b: 16'h0};
        for (int j = 0; j < 8; j++) m_hist[j] = 0;
        m_lane[0] = z;
        m_lane[1] = z;
        m_step    = 0;
    endtask

    task automatic check_feedback(input string tag);
        check({tag, "_hist"}, interval_cnt_o, m_hist_vec());
        check({tag, "_maxcnt"}, {48'h0, max_cnt_o}, {48'h0, m_lane[1].cnt, m_lane[0].cnt});
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctl"}, {62'h0, busy, out_valid}, 64'h0);
        check({tag, "_res"}, {mode_o, cnt_o, alpha_o, nalpha_o, beta_o}, 64'h0);
        check({tag, "_hist"}, interval_cnt_o, 64'h0);
        check({tag, "_maxcnt"}, {48'h0, max_cnt_o}, 64'h0);
    endtask

    task automatic do_start(input int j);
        start  = 1'b1;
        J_size = j[7:0];
        @(posedge clk); #1;
        start = 1'b0;
        model_clear();
        m_j = j;
        if (j == 0) begin
            last_res = m_result();
            exp_q.push_back(last_res);
            check("start0_ctl", {62'h0, busy, out_valid}, 64'h1);
        end else begin
            check("start_ctl", {62'h0, busy, out_valid}, 64'h2);
        end
        check_feedback("start");
    endtask

    task automatic do_beat(input logic v, input logic [1:0] u, input logic [1:0][7:0] md,
                           input logic [1:0][7:0] cn, input logic [1:0][7:0] acc,
                           input logic [1:0][15:0] a, input logic [1:0][15:0] na,
                           input logic [1:0][15:0] b);
        in_valid = v; U_add_i = u; mode_i = md; max_cnt_i = cn; acc_interval_i = acc;
        alpha_i = a; nalpha_i = na; beta_i = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (v) begin
            m_step++;
            for (int j = 0; j < 8; j++) begin
                m_hist[j] += int'(acc[0][j]) + int'(acc[1][j]);
                if (m_hist[j] > 255) m_hist[j] = 255;
            end
            for (int l = 0; l < 2; l++) begin
                if (u[l]) m_lane[l] = '{mode: md[l], cnt: cn[l], a: a[l], na: na[l], b: b[l]};
            end
        end
        check_feedback("beat");
        if (m_step == m_j) begin
            last_res = m_result();
            exp_q.push_back(last_res);
            check("final_ctl", {62'h0, busy, out_valid}, 64'h1);
        end else begin
            check("beat_ctl", {62'h0, busy, out_valid}, 64'h2);
        end
    endtask

    task automatic rnd_beat(input logic v);
        logic [1:0][7:0]  md, cn, acc;
        logic [1:0][15:0] a, na, b;
        for (int l = 0; l < 2; l++) begin
            md[l]  = 8'(1 << $urandom_range(0, 7));
            cn[l]  = 8'($urandom_range(0, 7));
            acc[l] = ($urandom_range(0, 1) == 0) ? 8'(1 << $urandom_range(0, 7))
                                                 : 8'($urandom);
            a[l]   = 16'($urandom);
            na[l]  = 16'($urandom);
            b[l]   = 16'($urandom);
        end
        do_beat(v, 2'($urandom), md, cn, acc, a, na, b);
    endtask

    // Hold off the consumer with junk start/in_valid, then accept alongside a start.
    task automatic do_accept(input int hold);
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0; start = 1'b1; J_size = 8'd5; in_valid = 1'b1;
            U_add_i = 2'b11; max_cnt_i = {8'hEE, 8'hEE}; acc_interval_i = {8'hFF, 8'hFF};
            @(posedge clk); #1;
            check("hold_valid", {63'h0, out_valid}, 64'h1);
        end
        out_ready = 1'b1; start = 1'b1; J_size = 8'd5; in_valid = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; start = 1'b0; in_valid = 1'b0; U_add_i = '0; acc_interval_i = '0;
        check("accept_ctl", {62'h0, busy, out_valid}, 64'h0);
        check_feedback("accept");
        check("accept_res", {mode_o, cnt_o, alpha_o, nalpha_o, beta_o},
              {last_res.mode, last_res.cnt, last_res.a, last_res.na, last_res.b});
        @(posedge clk); #1;
        check("idle_stays", {62'h0, busy, out_valid}, 64'h0);
    endtask

    // Monitor: pop one expectation per result, then require it to stay stable.
    logic [63:0] held;
    logic        prev_v = 1'b0;
    initial begin
        res_t r;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_v = 1'b0;
            end else begin
                if (out_valid && !prev_v) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL sb_unexpected: got result with empty queue, required none");
                    end else begin
                        r = exp_q.pop_front();
                        check("sb_result", {mode_o, cnt_o, alpha_o, nalpha_o, beta_o},
                              {r.mode, r.cnt, r.a, r.na, r.b});
                    end
                    held = {mode_o, cnt_o, alpha_o, nalpha_o, beta_o};
                end else if (out_valid) begin
                    check("sb_stable", {mode_o, cnt_o, alpha_o, nalpha_o, beta_o}, held);
                end
                prev_v = out_valid;
            end
        end
    end

    logic [1:0][7:0]  z8  = '0;
    logic [1:0][15:0] z16 = '0;

    initial begin
        model_clear();
        m_j = 0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Histogram only, no lane updates.
        do_start(4);
        repeat (4) do_beat(1'b1, 2'b00, z8, z8, {8'h01, 8'h01}, z16, z16, z16);
        check("t1_hist_const", interval_cnt_o, 64'h8);
        check("t1_res_const", {mode_o, cnt_o}, 64'h0);
        do_accept(2);

        // Lane 1 overtakes lane 0.
        do_start(3);
        do_beat(1'b1, 2'b01, {8'h00, 8'h04}, {8'd0, 8'd2}, z8, {16'h0, 16'h3C00}, z16, z16);
        do_beat(1'b1, 2'b10, {8'h10, 8'h00}, {8'd3, 8'd0}, z8, {16'h4000, 16'h0}, z16, z16);
        check("t2_maxcnt_const", {48'h0, max_cnt_o}, 64'h0302);
        do_beat(1'b1, 2'b00, z8, z8, z8, z16, z16, z16);
        check("t2_res_const", {mode_o, cnt_o, alpha_o}, {32'h0, 8'h10, 8'd3, 16'h4000});
        do_accept(1);

        // Tie goes to lane 0.
        do_start(1);
        do_beat(1'b1, 2'b11, {8'h40, 8'h02}, {8'd5, 8'd5}, z8,
                {16'h2222, 16'h1111}, {16'h3333, 16'h4444}, {16'h5555, 16'h6666});
        check("tie_const", {mode_o, alpha_o, nalpha_o, beta_o},
              {8'h0, 8'h02, 16'h1111, 16'h4444, 16'h6666});
        do_accept(0);

        // Saturation on interval 7, then a fresh start must clear it.
        do_start(130);
        repeat (130) do_beat(1'b1, 2'b00, z8, z8, {8'h80, 8'h80}, z16, z16, z16);
        check("sat_const", {56'h0, interval_cnt_o[7]}, 64'hFF);
        do_accept(1);
        do_start(1);
        check("sat_cleared", interval_cnt_o, 64'h0);
        do_beat(1'b1, 2'b00, z8, z8, {8'h80, 8'h80}, z16, z16, z16);
        do_accept(0);

        // Zero-length run held off for five cycles.
        do_start(0);
        do_accept(5);

        // Reset mid-run, then repeat the first scenario from scratch.
        do_start(6);
        rnd_beat(1'b1);
        rnd_beat(1'b1);
        rst = 1'b1;
        #1;
        check_zero("midrst");
        @(posedge clk); #1;
        check_zero("midrst_hold");
        rst = 1'b0;
        model_clear();
        @(posedge clk); #1;
        do_start(4);
        repeat (4) do_beat(1'b1, 2'b00, z8, z8, {8'h01, 8'h01}, z16, z16, z16);
        check("rerun_hist_const", interval_cnt_o, 64'h8);
        do_accept(1);

        // Randomized runs with idle gaps on in_valid.
        for (int r = 0; r < 20; r++) begin
            do_start($urandom_range(1, 10));
            while (m_step < m_j) rnd_beat(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
            do_accept($urandom_range(0, 3));
        end

        repeat (3) @(posedge clk);
        check("sb_drained", 64'(exp_q.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
